// File: rtl/telemetry_framer.sv
// telemetry_framer: snapshots NUM_CH channels of CH_BYTES bytes each.
// Streams them to a serial_tx as one packet: SYNC0 SYNC1 seq LEN payload CK.
// The checksum covers seq, LEN and the payload, and is accumulated as bytes go out.
`timescale 1ns/1ps
module telemetry_framer #(
  parameter int         NUM_CH     = 8,
  parameter int         CH_BYTES   = 4,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A,
  parameter int         CKSUM_MODE = 0,
  parameter int         PERIOD     = 0,
  parameter int         PERIOD_W   = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
  input  logic                         start,
  input  logic                         tx_busy,
  input  logic                         tx_block,
  output logic [7:0]                   data_tx,
  output logic                         new_data_tx,
  output logic                         frame_busy,
  output logic                         frame_done,
  output logic [7:0]                   seq,
  output logic [7:0]                   overrun_cnt
);

  localparam int         LEN      = NUM_CH * CH_BYTES;
  localparam int         DW       = LEN * 8;
  localparam logic [8:0] LAST_IDX = 9'(LEN + 4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state_reg;
  logic [8:0]    idx_reg;
  logic [7:0]    acc_reg;
  logic [DW-1:0] snap_reg;
  logic [DW-1:0] snap_next;
  logic [7:0]    data_tx_reg;
  logic          new_data_tx_reg;
  logic          frame_busy_reg;
  logic          frame_done_reg;
  logic [7:0]    seq_reg;
  logic [7:0]    overrun_reg;

  logic          auto_trig;
  logic          trigger;
  logic          accept;
  logic [7:0]    cur_byte;
  logic [7:0]    ck_byte;
  logic [7:0]    acc_next;

  // Free-running auto-trigger counter, independent of frame state.
  generate
    if (PERIOD != 0) begin : g_period
      logic [PERIOD_W-1:0] period_cnt_reg;

      // Count 0..PERIOD-1 and wrap.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          period_cnt_reg <= '0;
        else if (period_cnt_reg == PERIOD_W'(PERIOD - 1))
          period_cnt_reg <= '0;
        else
          period_cnt_reg <= period_cnt_reg + 1'b1;
      end

      assign auto_trig = (period_cnt_reg == PERIOD_W'(PERIOD - 1));
    end else begin : g_no_period
      assign auto_trig = 1'b0;
    end
  endgenerate

  // Reorder the channels into transmit order: channel 0 first, MSB byte first.
  // The top byte of the snapshot is always the next payload byte to go out.
  generate
    for (genvar gi = 0; gi < LEN; gi++) begin : g_snap
      localparam int CH = gi / CH_BYTES;
      localparam int BY = gi % CH_BYTES;
      assign snap_next[DW-1-gi*8 -: 8] = ch_data[CH*CH_BYTES*8 + (CH_BYTES-1-BY)*8 +: 8];
    end
  endgenerate

  // A trigger is only taken in IDLE and outside the frame_done cycle.
  assign trigger  = start | auto_trig;
  assign accept   = trigger && (state_reg == S_IDLE) && !frame_done_reg;
  assign ck_byte  = (CKSUM_MODE == 0) ? (8'h00 - acc_reg) : acc_reg;
  assign acc_next = (CKSUM_MODE == 0) ? (acc_reg + cur_byte) : (acc_reg ^ cur_byte);

  // Select the byte for the current frame position.
  always_comb begin
    cur_byte = snap_reg[DW-1 -: 8];
    if (idx_reg == 9'd0)
      cur_byte = SYNC0;
    else if (idx_reg == 9'd1)
      cur_byte = SYNC1;
    else if (idx_reg == 9'd2)
      cur_byte = seq_reg;
    else if (idx_reg == 9'd3)
      cur_byte = 8'(LEN);
    else if (idx_reg == LAST_IDX)
      cur_byte = ck_byte;
  end

  // Frame sequencer: IDLE -> SEND -> GAP -> SEND ... -> IDLE, plus overrun accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      acc_reg         <= '0;
      snap_reg        <= '0;
      data_tx_reg     <= '0;
      new_data_tx_reg <= 1'b0;
      frame_busy_reg  <= 1'b0;
      frame_done_reg  <= 1'b0;
      seq_reg         <= '0;
      overrun_reg     <= '0;
    end else begin
      new_data_tx_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      if (trigger && !accept && overrun_reg != 8'hFF)
        overrun_reg <= overrun_reg + 8'd1;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            snap_reg       <= snap_next;
            acc_reg        <= '0;
            idx_reg        <= '0;
            frame_busy_reg <= 1'b1;
            state_reg      <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy && !tx_block) begin
            data_tx_reg     <= cur_byte;
            new_data_tx_reg <= 1'b1;
            state_reg       <= S_GAP;
            if (idx_reg >= 9'd2 && idx_reg != LAST_IDX)
              acc_reg <= acc_next;
            if (idx_reg >= 9'd4 && idx_reg != LAST_IDX)
              snap_reg <= snap_reg << 8;
          end
        end
        S_GAP: begin
          if (idx_reg == LAST_IDX) begin
            state_reg      <= S_IDLE;
            frame_done_reg <= 1'b1;
            frame_busy_reg <= 1'b0;
            seq_reg        <= seq_reg + 8'd1;
          end else begin
            idx_reg   <= idx_reg + 9'd1;
            state_reg <= S_SEND;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign data_tx     = data_tx_reg;
  assign new_data_tx = new_data_tx_reg;
  assign frame_busy  = frame_busy_reg;
  assign frame_done  = frame_done_reg;
  assign seq         = seq_reg;
  assign overrun_cnt = overrun_reg;

endmodule
